// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write port, two read ports, clear handshake and flat image.
// Parameters must match the regfile_param instance they are connected to.
interface regfile_param_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic                     WR;
    logic [ADDR_W-1:0]        WA;
    logic [WIDTH-1:0]         LD_DATA;
    logic [ADDR_W-1:0]        RA0;
    logic [ADDR_W-1:0]        RA1;
    logic [WIDTH-1:0]         RD0;
    logic [WIDTH-1:0]         RD1;
    logic                     CLR_REQ;
    logic                     BUSY;
    logic                     CLR_DONE;
    logic                     WR_ERR;
    logic [WIDTH*DEPTH-1:0]   DATA_ALL;

    modport master (
        output WR, WA, LD_DATA, RA0, RA1, CLR_REQ,
        input  RD0, RD1, BUSY, CLR_DONE, WR_ERR, DATA_ALL
    );

    modport slave (
        input  WR, WA, LD_DATA, RA0, RA1, CLR_REQ,
        output RD0, RD1, BUSY, CLR_DONE, WR_ERR, DATA_ALL
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with two registered read ports, flat image and a clear sweeper.
// Optional macro REGFILE_PARAM_BYPASS_EN: read ports capture same-edge writes (write-through).
module regfile_param #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic           CLK,
    input  logic           CLRN,
    regfile_param_if.slave bus
);
    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  rd0_q, rd0_d;
    logic [WIDTH-1:0]  rd1_q, rd1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [WIDTH-1:0]  wr_data_c;

    // State register
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a clear request starts the sweep, the last index ends it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.CLR_REQ)       state_d = CLEAR;
            CLEAR: if (idx_q == LAST_IDX) state_d = IDLE;
        endcase
    end

    // Outputs and write arbitration; the sweep owns the write port while active
    always_comb begin
        idx_d     = idx_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wr_en_c   = 1'b0;
        wr_addr_c = bus.WA;
        wr_data_c = bus.LD_DATA;
        unique case (state_q)
            IDLE: begin
                if (bus.CLR_REQ) begin
                    idx_d  = '0;
                    busy_d = 1'b1;
                    err_d  = bus.WR;
                end else if (bus.WR) begin
                    wr_en_c = 1'b1;
                end
            end
            CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = idx_q;
                wr_data_c = '0;
                err_d     = bus.WR;
                if (idx_q == LAST_IDX) begin
                    done_d = 1'b1;
                end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    busy_d = 1'b1;
                end
            end
        endcase
    end

    // Array update and read capture
    always_comb begin
        mem_d = mem_q;
        if (wr_en_c) begin
            mem_d[wr_addr_c] = wr_data_c;
        end
`ifdef REGFILE_PARAM_BYPASS_EN
        rd0_d = mem_d[bus.RA0];
        rd1_d = mem_d[bus.RA1];
`else
        rd0_d = mem_q[bus.RA0];
        rd1_d = mem_q[bus.RA1];
`endif
    end

    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            idx_q  <= '0;
            rd0_q  <= '0;
            rd1_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            idx_q  <= idx_d;
            rd0_q  <= rd0_d;
            rd1_q  <= rd1_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            mem_q  <= mem_d;
        end
    end

    assign bus.RD0      = rd0_q;
    assign bus.RD1      = rd1_q;
    assign bus.BUSY     = busy_q;
    assign bus.CLR_DONE = done_q;
    assign bus.WR_ERR   = err_q;

    // Flat image straight from the array, entry i at bits [i*WIDTH +: WIDTH]
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign bus.DATA_ALL[g*WIDTH +: WIDTH] = mem_q[g];
    end

    a_busy_tracks_state: assert property (@(posedge CLK) disable iff (!CLRN)
        busy_q == (state_q == CLEAR));
    a_done_not_busy: assert property (@(posedge CLK) disable iff (!CLRN)
        !(busy_q && done_q));
    a_done_single: assert property (@(posedge CLK) disable iff (!CLRN)
        done_q |=> !done_q);
endmodule
